data_memory_responder: RTL and testbench

- Word-addressed data memory that answers the load/store requests issued by the single-cycle MIPS datapath.
- Accepts the datapath's byte-array address/data interface and adds a configurable access latency.
- Holds the datapath with a combinational `stall` (gates `pc_we` and register write) until the access completes.
- Signals completion with a one-cycle `mem_ready` pulse and flags misaligned accesses.

---
 rtl/data_memory_responder.sv | 215 +++++++++++++++++++++
 tb/tb_data_memory_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//
// Word-addressed data memory serving load/store requests from a single-cycle
// MIPS datapath. Each access takes exactly LATENCY stall cycles. Completion is
// signalled by a one-cycle mem_ready pulse. Misaligned accesses complete with
// the same latency, write nothing, and raise mem_error with mem_ready.
//
// Ports:
//   clk            rising-edge system clock
//   rst_b          asynchronous reset, active HIGH despite the name
//   mem_addr       byte address (upper bits above ADDR_BITS+1 are ignored)
//   mem_data_in    store data, [0] = least-significant byte
//   mem_read_en    load request
//   mem_write_en   store request
//   mem_data_out   registered load data, [0] = least-significant byte
//   stall          combinational hold for the datapath while an access is pending
//   mem_ready      one-cycle completion pulse (registered)
//   mem_error      one-cycle misalignment flag, coincident with mem_ready
// ---------------------------------------------------------------------------
module data_memory_responder #(
    parameter int XLEN      = 32,
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [7:0]      mem_data_in [0:3],
    input  logic            mem_read_en,
    input  logic            mem_write_en,
    output logic [7:0]      mem_data_out [0:3],
    output logic            stall,
    output logic            mem_ready,
    output logic            mem_error
);

    localparam int         DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0] LAT4  = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS+1:0]   addr_q;
    logic [31:0]            data_q;
    logic                   we_q;
    logic                   re_q;
    logic [31:0]            dout_q, dout_d;
    logic                   mem_ready_q, mem_ready_d;
    logic                   mem_error_q, mem_error_d;

    // Four byte lanes; lane k holds the byte at word address + k.
    logic [7:0]             bank_q [0:3][0:DEPTH-1];

    logic                   req_s;
    logic                   stall_s;
    logic                   commit_s;
    logic [ADDR_BITS+1:0]   c_addr_s;
    logic [31:0]            c_data_s;
    logic                   c_we_s;
    logic                   c_re_s;
    logic                   mis_s;
    logic                   wr_en_s;
    logic [ADDR_BITS-1:0]   idx_s;
    logic [31:0]            rd_word_s;
    logic [31:0]            din_s;
    logic                   unused_addr_s;

    assign req_s = mem_read_en | mem_write_en;
    assign din_s = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};

    // Address bits above the word index only alias; fold them so they are consumed.
    assign unused_addr_s = ^mem_addr[XLEN-1:ADDR_BITS+2];

    // With LATENCY==1 the commit happens in IDLE straight from the live inputs;
    // otherwise it happens in BUSY from the values captured at acceptance.
    always_comb begin
        if (state_q == IDLE) begin
            c_addr_s = mem_addr[ADDR_BITS+1:0];
            c_data_s = din_s;
            c_we_s   = mem_write_en;
            c_re_s   = mem_read_en;
        end else begin
            c_addr_s = addr_q;
            c_data_s = data_q;
            c_we_s   = we_q;
            c_re_s   = re_q;
        end
    end

    assign mis_s     = |c_addr_s[1:0];
    assign idx_s     = c_addr_s[ADDR_BITS+1:2];
    // Reset aborts an in-flight write even on a coincident clock edge.
    assign wr_en_s   = commit_s & c_we_s & ~mis_s & ~rst_b;
    assign rd_word_s = {bank_q[3][idx_s], bank_q[2][idx_s], bank_q[1][idx_s], bank_q[0][idx_s]};

    // Next-state, latency counter and stall decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_s = 1'b0;
        stall_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    stall_s = 1'b1;
                    if (LATENCY == 1) begin
                        commit_s = 1'b1;
                        cnt_d    = 4'd0;
                        state_d  = DONE;
                    end else begin
                        cnt_d    = 4'd1;
                        state_d  = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if ((cnt_q + 4'd1) == LAT4) begin
                    commit_s = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = DONE;
                end else begin
                    cnt_d    = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Load-data next value; a combined read/write returns the stored data.
    always_comb begin
        dout_d = dout_q;
        if (commit_s) begin
            if (mis_s) begin
                if (c_re_s) begin
                    dout_d = 32'd0;
                end else begin
                    dout_d = dout_q;
                end
            end else if (c_re_s) begin
                if (c_we_s) begin
                    dout_d = c_data_s;
                end else begin
                    dout_d = rd_word_s;
                end
            end else begin
                dout_d = dout_q;
            end
        end else begin
            dout_d = dout_q;
        end
    end

    assign mem_ready_d = commit_s;
    assign mem_error_d = commit_s & mis_s;

    // State, counter, captured request and registered outputs.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            data_q      <= 32'd0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            dout_q      <= 32'd0;
            mem_ready_q <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            mem_ready_q <= mem_ready_d;
            mem_error_q <= mem_error_d;
            if ((state_q == IDLE) && req_s) begin
                addr_q <= mem_addr[ADDR_BITS+1:0];
                data_q <= din_s;
                we_q   <= mem_write_en;
                re_q   <= mem_read_en;
            end
        end
    end

    // Storage array; never reset. Reads above see pre-edge contents.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int k = 0; k < 4; k++) begin
                bank_q[k][idx_s] <= c_data_s[8*k +: 8];
            end
        end
    end

    assign stall           = stall_s & ~rst_b;
    assign mem_ready       = mem_ready_q;
    assign mem_error       = mem_error_q;
    assign mem_data_out[0] = dout_q[7:0];
    assign mem_data_out[1] = dout_q[15:8];
    assign mem_data_out[2] = dout_q[23:16];
    assign mem_data_out[3] = dout_q[31:24];

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

    localparam int NI = 3;

    typedef struct {
        int          inst;
        logic [31:0] data;
        logic        chk;
        logic        err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_b = 1'b1;
    logic [31:0]    addr_p [NI];
    logic [31:0]    din_p  [NI];
    logic [NI-1:0]  re_v;
    logic [NI-1:0]  we_v;
    logic [31:0]    dout_p [NI];
    logic [NI-1:0]  stall_v;
    logic [NI-1:0]  rdy_v;
    logic [NI-1:0]  err_v;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    // Instance 0: LATENCY=2, instance 1: LATENCY=1, instance 2: LATENCY=5.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
        logic [7:0] din_u  [0:3];
        logic [7:0] dout_u [0:3];
        logic       st, rd, er;
        assign din_u[0] = din_p[g][7:0];
        assign din_u[1] = din_p[g][15:8];
        assign din_u[2] = din_p[g][23:16];
        assign din_u[3] = din_p[g][31:24];
        data_memory_responder #(.XLEN(32), .ADDR_BITS(10), .LATENCY(LAT)) u_dut (
            .clk          (clk),
            .rst_b        (rst_b),
            .mem_addr     (addr_p[g]),
            .mem_data_in  (din_u),
            .mem_read_en  (re_v[g]),
            .mem_write_en (we_v[g]),
            .mem_data_out (dout_u),
            .stall        (st),
            .mem_ready    (rd),
            .mem_error    (er)
        );
        assign dout_p[g]  = {dout_u[3], dout_u[2], dout_u[1], dout_u[0]};
        assign stall_v[g] = st;
        assign rdy_v[g]   = rd;
        assign err_v[g]   = er;
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One datapath access: hold the request while stalled, count stall cycles,
    // drop it once mem_ready is seen, then leave one cycle before the next.
    task automatic access(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic r, input logic w, input logic [31:0] exp_d,
                          input logic chk, input logic exp_e, input string nm);
        exp_t e;
        int   n;
        bit   got;
        e.inst = i; e.data = exp_d; e.chk = chk; e.err = exp_e;
        @(negedge clk);
        addr_p[i] = a; din_p[i] = d; re_v[i] = r; we_v[i] = w;
        exp_q.push_back(e);
        #1;
        n = 0;
        got = 1'b0;
        if (stall_v[i]) n++;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk);
            #1;
            if (rdy_v[i]) got = 1'b1;
            else if (stall_v[i]) n++;
        end
        re_v[i] = 1'b0;
        we_v[i] = 1'b0;
        chk32({nm, "_ready_seen"}, 32'(got), 32'd1);
        chk32({nm, "_stall_cycles"}, n, lat_of(i));
        @(negedge clk);
    endtask

    // Scoreboard monitor: compares every completion against the queue head.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (err_v[i] && !rdy_v[i]) begin
                n_total++;
                $display("FAIL error_without_ready: inst %0d got error=1 ready=0 required ready=1", i);
            end
            if (rdy_v[i]) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_ready: inst %0d got ready with empty queue required none", i);
                end else begin
                    e = exp_q.pop_front();
                    chk32("ready_instance", i, e.inst);
                    if (e.chk) chk32("rd_data", dout_p[i], e.data);
                    chk32("mem_error", 32'(err_v[i]), 32'(e.err));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            addr_p[i] = 32'd0;
            din_p[i]  = 32'd0;
        end
        re_v = '0;
        we_v = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk32("rst_stall", 32'(stall_v[i]), 32'd0);
            chk32("rst_ready", 32'(rdy_v[i]), 32'd0);
            chk32("rst_error", 32'(err_v[i]), 32'd0);
            chk32("rst_dout", dout_p[i], 32'd0);
        end
        rst_b = 1'b0;
        @(negedge clk);

        access(0, 32'h40,   32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, "wr40");
        access(0, 32'h40,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, "rd40");
        access(0, 32'h104,  32'h55AA55AA, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, "wr104");
        access(0, 32'h100,  32'h12345678, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, "wr100");
        access(0, 32'h104,  32'h0,        1'b1, 1'b0, 32'h55AA55AA, 1'b1, 1'b0, "rd104");
        access(0, 32'h1100, 32'h0,        1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0, "rd_alias");
        access(0, 32'h42,   32'hFFFFFFFF, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, "wr_mis42");
        access(0, 32'h40,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, "rd40_after_mis");
        access(0, 32'h41,   32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, "rd_mis41");
        access(0, 32'h80,   32'h0BADC0DE, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, "wr80");
        access(0, 32'h80,   32'h0,        1'b1, 1'b0, 32'h0BADC0DE, 1'b1, 1'b0, "rd80");

        // Reset in cycle 1 of a write must abort it and clear outputs at once.
        @(negedge clk);
        addr_p[0] = 32'h80; din_p[0] = 32'hCAFEF00D; we_v[0] = 1'b1;
        @(posedge clk);
        #1;
        chk32("abort_busy_stall", 32'(stall_v[0]), 32'd1);
        rst_b = 1'b1;
        #1;
        chk32("abort_stall", 32'(stall_v[0]), 32'd0);
        chk32("abort_ready", 32'(rdy_v[0]), 32'd0);
        chk32("abort_dout", dout_p[0], 32'd0);
        @(negedge clk);
        we_v[0] = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        access(0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h0BADC0DE, 1'b1, 1'b0, "rd80_after_abort");

        access(0, 32'h20, 32'hA5A5A5A5, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, "rw20");
        access(0, 32'h20, 32'h0,        1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0, "rd20");

        for (int i = 0; i < NI; i++) begin
            access(i, 32'h10, 32'h11111111, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, "b2b_wr10");
            access(i, 32'h10, 32'h0,        1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0, "b2b_rd10");
        end

        repeat (4) @(negedge clk);
        chk32("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
